// File: rtl/rs_pkg.sv
// Shared types and field layout for the reservation-station issue scheduler.
// The 83-bit decomposed instruction is modelled as a packed struct, ctrl in the LSBs.
package rs_pkg;

    localparam int INST_W    = 83;
    localparam int CTRL_LSB  = 0;
    localparam int RD_LSB    = 12;
    localparam int S1V_BIT   = 17;
    localparam int RS1_LSB   = 18;
    localparam int S2V_BIT   = 50;
    localparam int RS2_LSB   = 51;

    localparam int DEF_TAG_W = 6;

    // Field order mirrors the bus layout, so a plain cast converts between them.
    typedef struct packed {
        logic [31:0] rs2_vt;
        logic        s2_valid;
        logic [31:0] rs1_vt;
        logic        s1_valid;
        logic [4:0]  rd;
        logic [11:0] ctrl;
    } inst_t;

    typedef struct packed {
        logic  busy;
        inst_t inst;
    } entry_t;

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, CDB and issue signal bundle of the reservation-station scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface rs_issue_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = rs_pkg::DEF_TAG_W
);

    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [rs_pkg::INST_W-1:0]    in_inst;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [31:0]                  cdb_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [rs_pkg::INST_W-1:0]    out_inst;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic [31:0]                  stall_cnt;

    modport master (
        output flush, in_valid, in_inst, cdb_valid, cdb_tag, cdb_data, out_ready,
        input  in_ready, out_valid, out_inst, occupancy, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_inst, cdb_valid, cdb_tag, cdb_data, out_ready,
        output in_ready, out_valid, out_inst, occupancy, stall_cnt
    );

endinterface

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker driven by an age matrix.
// age[i][j]=1 means entry i is older than entry j; the diagonal is ignored.
module rs_age_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        grant_valid
);

    // An entry wins if it is ready and older than every other ready entry.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && !(age[i][j] || (j == i))) begin
                    grant[i] = 1'b0;
                end
            end
        end
        grant_valid = |grant;
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: buffers renamed instructions, wakes operands from the CDB,
// issues the oldest ready entry through a registered valid/ready stage. Option: RS_PERF_CNT_EN.
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    rs_issue_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    entry_t                     ent_q [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic                       out_valid_q;
    inst_t                      out_inst_q;
    logic [OCC_W-1:0]           occ_q;

    logic [DEPTH-1:0]           busy;
    logic [DEPTH-1:0]           ready;
    logic [DEPTH-1:0]           grant;
    logic                       grant_valid;
    logic                       in_ready;
    logic                       dispatch;
    logic                       load_out;
    logic [IDX_W-1:0]           free_idx;
    logic [IDX_W-1:0]           grant_idx;
    inst_t                      in_inst;
    inst_t                      new_inst;

    assign in_inst = inst_t'(bus.in_inst);

    // Readiness uses registered operand state only, so a CDB hit becomes eligible one cycle later.
    always_comb begin
        busy  = '0;
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && ent_q[i].inst.s1_valid && ent_q[i].inst.s2_valid;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

    assign in_ready = ~&busy;
    assign dispatch = bus.in_valid && in_ready && !bus.flush;
    assign load_out = grant_valid && (!out_valid_q || bus.out_ready) && !bus.flush;

    rs_age_select #(
        .DEPTH(DEPTH)
    ) u_age_select (
        .ready       (ready),
        .age         (age_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // An operand broadcast in the dispatch cycle is captured here so the wakeup is not lost.
    always_comb begin
        new_inst = in_inst;
        if (bus.cdb_valid && !in_inst.s1_valid && (in_inst.rs1_vt[TAG_W-1:0] == bus.cdb_tag)) begin
            new_inst.rs1_vt   = bus.cdb_data;
            new_inst.s1_valid = 1'b1;
        end
        if (bus.cdb_valid && !in_inst.s2_valid && (in_inst.rs2_vt[TAG_W-1:0] == bus.cdb_tag)) begin
            new_inst.rs2_vt   = bus.cdb_data;
            new_inst.s2_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dispatch && (free_idx == IDX_W'(i))) begin
                    ent_q[i].busy <= 1'b1;
                    ent_q[i].inst <= new_inst;
                end else if (ent_q[i].busy) begin
                    if (load_out && grant[i]) begin
                        ent_q[i].busy <= 1'b0;
                    end
                    if (bus.cdb_valid && !ent_q[i].inst.s1_valid &&
                        (ent_q[i].inst.rs1_vt[TAG_W-1:0] == bus.cdb_tag)) begin
                        ent_q[i].inst.rs1_vt   <= bus.cdb_data;
                        ent_q[i].inst.s1_valid <= 1'b1;
                    end
                    if (bus.cdb_valid && !ent_q[i].inst.s2_valid &&
                        (ent_q[i].inst.rs2_vt[TAG_W-1:0] == bus.cdb_tag)) begin
                        ent_q[i].inst.rs2_vt   <= bus.cdb_data;
                        ent_q[i].inst.s2_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // A new entry rewrites its whole row and column: younger than everything currently busy.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            age_q <= '0;
        end else if (dispatch) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(i) == free_idx) begin
                        age_q[i][j] <= 1'b0;
                    end else if (IDX_W'(j) == free_idx) begin
                        age_q[i][j] <= busy[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= ent_q[grant_idx].inst;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(dispatch) - OCC_W'(load_out);
        end
    end

`ifdef RS_PERF_CNT_EN
    logic [31:0] stall_q;

    // Survives flush on purpose: it measures upstream pressure across mispredictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.occupancy = occ_q;

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Reservation-station scheduler between the decode/rename stage and one functional unit.
- Buffers 83-bit decomposed instructions, tracks operand readiness and captures results from the common data bus (CDB).
- Issues the oldest entry whose operands are both ready to the FU through a registered valid/ready output stage.
- Decode-side flush clears all pending work on misprediction.

Parameters:
- DEPTH, 4, number of reservation-station entries (2..8).
- TAG_W, 6, rename tag width; a not-ready operand holds its tag in vt[TAG_W-1:0].
- INST_W, 83, decomposed instruction width; fixed layout {rs2_vt[31:0], s2_valid, rs1_vt[31:0], s1_valid, rd[4:0], ctrl[11:0]}, LSB first from ctrl.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all entries and the output register
- in_valid  in  1  decomposed instruction offered
- in_ready  out  1  at least one free entry
- in_inst  in  INST_W  decomposed instruction
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producer tag
- cdb_data  in  32  result value
- out_valid  out  1  issued instruction held
- out_ready  in  1  FU accepts
- out_inst  out  INST_W  issued instruction, both valid bits = 1
- occupancy  out  $clog2(DEPTH+1)  live entries
- stall_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - all entries invalid; age matrix cleared; out_valid=0; out_inst=0; occupancy=0; stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Entry fields: busy, rs1_vt, s1_valid, rs2_vt, s2_valid, rd, ctrl.
- Age: DEPTHxDEPTH age matrix. Bit [i][j]=1 means entry i is older than entry j.
- Dispatch:
  - Accept when in_valid && in_ready.
  - Write into the lowest-index free entry; set the age row so the new entry is younger than every busy entry.
  - in_ready is a function of registered busy bits only; a slot freed this cycle is reusable next cycle.
- Wakeup:
  - On cdb_valid, each busy entry with sN_valid=0 and vt[TAG_W-1:0]==cdb_tag loads cdb_data into vt and sets sN_valid=1.
  - rs1 and rs2 match independently.
  - Same-cycle dispatch: if the incoming operand is not ready and matches cdb_tag, store cdb_data with valid=1. No lost wakeup.
- Select:
  - Ready = busy && s1_valid && s2_valid, using registered values.
  - An entry woken this cycle is eligible next cycle (minimum wakeup-to-issue latency 1).
  - Pick the ready entry older than all other ready entries.
  - Load into the output register when !out_valid || out_ready; clear that entry's busy bit the same edge.
- Output handshake:
  - out_inst held stable while out_valid && !out_ready.
  - Back-to-back issue once per cycle when out_ready=1.
  - Minimum latency, dispatch of a fully ready instruction to out_valid: 2 cycles.
- Full (DEPTH busy): in_ready=0; in_valid is ignored.
- Empty: out_valid is cleared after the last accepted transfer.
- Occupancy: registered count of busy entries.
  - Simultaneous dispatch and issue leaves it unchanged.
  - Range 0..DEPTH; never wraps.
- Flush:
  - Next edge: all busy=0, out_valid=0; same-cycle dispatch and CDB ignored.
  - Takes effect mid-wakeup or mid-stall without residue.
- Dispatch order does not depend on the dispatch_control bits (ctrl[1:0]); upstream routing selects this RS.

Optional Feature:
- Macro: RS_PERF_CNT_EN.
- Defined: stall_cnt increments (saturating at 0xFFFFFFFF) each cycle in_valid && !in_ready; cleared by rst only, not by flush.
- Undefined: stall_cnt tied to 0; counter logic absent.

Decomposition:
- Package rs_pkg holds:
  - INST_W and field-offset localparams: CTRL_LSB=0, RD_LSB=12, S1V_BIT=17, RS1_LSB=18, S2V_BIT=50, RS2_LSB=51.
  - Default TAG_W.
  - Entry struct/typedef.
- Sub-module rs_age_select: combinational age-matrix oldest-ready picker.
  - Input: ready vector and age matrix.
  - Output: one-hot grant and grant_valid.

Test Plan:
- Ready pass-through: dispatch one inst with s1_valid=s2_valid=1, rs1_vt=5, rs2_vt=7, rd=3, out_ready=1 -> out_valid at cycle +2, out_inst equal to input, occupancy 1 then 0.
- Wakeup: dispatch rs1 tag 0x0A not ready; 3 cycles later cdb_valid, tag 0x0A, data 0xDEADBEEF -> out_valid the cycle after capture, rs1_vt=0xDEADBEEF, s1_valid=1.
- Same-cycle capture: dispatch rs2 tag 0x11 while cdb broadcasts tag 0x11, data 0x1234 -> issued with rs2_vt=0x1234; no hang.
- Age order: dispatch A (tag 1), B (tag 2), C (ready); broadcast tag 2 then tag 1 -> issue order C, B, A; with out_ready=0 for 3 cycles, out_inst stays constant.
- Full/backpressure: fill 4 entries, out_ready=0, hold in_valid 5 cycles -> in_ready=0, no entry overwritten, stall_cnt=5 with RS_PERF_CNT_EN.
- Flush/reset: flush with 3 entries and out_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; rst mid-stall gives the same result and stall_cnt=0.
